gpu_axi_regs: RTL
=================

Name: gpu_axi_regs

Overview:
- AXI4-lite slave register file: the host-facing control block that drives the GPU frame sequencer.
- Holds the triangle count and the vertex/color base addresses, issues a one-cycle frame start, and tracks busy/done from the sequencer's frame-end pulse.
- Generates the level interrupt to the host.

Parameters:
- SADDR_WIDTH, 32, AXI slave address width; only bits [4:2] are decoded.
- MADDR_WIDTH, 32, width of the base address outputs.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- awaddr  in  SADDR_WIDTH  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  SADDR_WIDTH  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- frame_end  in  1  one-cycle pulse from the sequencer: last triangle finished
- frame_start  out  1  one-cycle start pulse to the sequencer
- triangles_count  out  32  TRI_COUNT register
- base_addr_vertex  out  MADDR_WIDTH  VTX_BASE register
- base_addr_color  out  MADDR_WIDTH  COL_BASE register
- irq  out  1  level interrupt

Behaviour:
- Reset: all registers, outputs, bvalid, rvalid, rdata, frame_start and irq = 0; awready = wready = arready = 0 in the reset cycle.

Register map (byte offset):
- 0x00 CTRL RW: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN.
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear).
- 0x08 TRI_COUNT RW.
- 0x0C VTX_BASE RW.
- 0x10 COL_BASE RW.
- 0x14 FRAME_CNT RO: frames completed, wraps 0xFFFFFFFF -> 0.
- Any other offset: reads return 0 with SLVERR (2'b10); writes have no effect and return SLVERR. Mapped accesses return OKAY (2'b00).

Write channel:
- AW and W are captured independently into holding registers. awready/wready stay high while the respective holding register is empty and bvalid = 0.
- Commit cycle = first cycle with both holding registers full. The register is updated per wstrb byte lane at commit, holding registers clear, and bvalid = 1 the next cycle, held until bready.
- No new AW/W is accepted while bvalid = 1.

Read channel:
- arready = !rvalid. On the arvalid && arready cycle, rdata/rresp are registered and rvalid = 1 the next cycle (latency 1), held stable until rready.

START:
- A committed CTRL write with wstrb[0] && wdata[0] while BUSY = 0 and TRI_COUNT != 0 -> frame_start = 1 for exactly the next cycle, BUSY = 1 from that cycle.
- START is ignored (OKAY response, no pulse) when BUSY = 1 or TRI_COUNT = 0.
- BUSY is evaluated in the commit cycle, so a START coinciding with frame_end is ignored.

frame_end (when BUSY = 1):
- Next cycle: BUSY = 0, DONE = 1, FRAME_CNT + 1.
- frame_end while BUSY = 0 is ignored.
- DONE W1C in the same cycle as a DONE set: set wins.

Other rules:
- irq = DONE && IRQ_EN, registered, 1-cycle lag.
- TRI_COUNT/VTX_BASE/COL_BASE writes while BUSY = 1 take effect immediately; software must not do this.
- Base registers wider than MADDR_WIDTH are truncated to MADDR_WIDTH.
- Reset mid-transaction: pending AW/W, bvalid and rvalid are dropped; BUSY clears; no frame_start is emitted.

Optional Feature:
- GPU_REGS_ID_EN defined: offset 0x18 is a read-only ID register returning 0x47505531 with OKAY; writes to it are ignored with OKAY.
- Undefined: 0x18 behaves as unmapped (SLVERR, rdata 0).

Test Plan:
- Reset, then read each of 0x00-0x14 -> all rdata = 0, rresp = OKAY; read 0x1C -> rdata 0, SLVERR.
- Write 0x08 = 12, 0x0C = 0x1000, 0x10 = 0x2000 with AW two cycles before W -> bvalid one cycle after W, OKAY; outputs = 12/0x1000/0x2000. Write 0x0C wstrb = 4'b0010 data 0xAB00 -> VTX_BASE = 0xAB00.
- IRQ_EN = 1, START -> frame_start high exactly 1 cycle, STATUS = 0x1; frame_end pulse -> STATUS = 0x2, irq = 1, FRAME_CNT = 1; write STATUS = 0x2 -> irq = 0.
- START while BUSY -> no frame_start pulse; START with TRI_COUNT = 0 -> no pulse, OKAY.
- Hold rready = 0 for 5 cycles after a read -> rvalid/rdata stable, arready = 0; hold bready = 0 -> awready = wready = 0 until bready.
- Read 0x18 with and without GPU_REGS_ID_EN -> 0x47505531/OKAY vs 0/SLVERR.

Source files
------------

// File: rtl/gpu_axi_regs.sv
// AXI4-lite register file driving the GPU frame sequencer: geometry setup, frame start, busy/done, irq.
// Optional define GPU_REGS_ID_EN maps a read-only ID register at offset 0x18.
module gpu_axi_regs #(
    parameter int unsigned SADDR_WIDTH = 32,
    parameter int unsigned MADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [SADDR_WIDTH-1:0] araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic                   frame_end,
    output logic                   frame_start,
    output logic [31:0]            triangles_count,
    output logic [MADDR_WIDTH-1:0] base_addr_vertex,
    output logic [MADDR_WIDTH-1:0] base_addr_color,
    output logic                   irq
);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_TRI    = 3'd2;
    localparam logic [2:0] IDX_VTX    = 3'd3;
    localparam logic [2:0] IDX_COL    = 3'd4;
    localparam logic [2:0] IDX_FCNT   = 3'd5;
`ifdef GPU_REGS_ID_EN
    localparam logic [2:0]  IDX_ID = 3'd6;
    localparam logic [31:0] GPU_ID = 32'h4750_5531;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_full;
    logic [2:0]  aw_idx;
    logic        w_full;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        irq_en;
    logic        busy;
    logic        done;
    logic [31:0] frame_cnt;

    logic        commit_c;
    logic        start_c;
    logic        wr_err_c;
    logic [2:0]  ar_idx_c;
    logic [31:0] rd_data_c;
    logic        rd_err_c;
    logic        unused_c;

    // Only address bits [4:2] select a register; protection bits carry no meaning here.
    assign unused_c = ^{awprot, arprot, awaddr[SADDR_WIDTH-1:5], awaddr[1:0],
                        araddr[SADDR_WIDTH-1:5], araddr[1:0]};

    assign awready  = !reset && !aw_full && !bvalid;
    assign wready   = !reset && !w_full && !bvalid;
    assign arready  = !reset && !rvalid;
    assign commit_c = aw_full && w_full;
    assign ar_idx_c = araddr[4:2];

    assign start_c = commit_c && (aw_idx == IDX_CTRL) && w_strb[0] && w_data[0]
                     && !busy && (triangles_count != 32'd0);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Write-side address decode.
    always_comb begin
        wr_err_c = 1'b1;
        case (aw_idx)
            IDX_CTRL, IDX_STATUS, IDX_TRI, IDX_VTX, IDX_COL, IDX_FCNT: wr_err_c = 1'b0;
`ifdef GPU_REGS_ID_EN
            IDX_ID: wr_err_c = 1'b0;
`endif
            default: wr_err_c = 1'b1;
        endcase
    end

    // Read data mux; START always reads back as 0.
    always_comb begin
        rd_data_c = 32'd0;
        rd_err_c  = 1'b0;
        case (ar_idx_c)
            IDX_CTRL:   rd_data_c = {30'd0, irq_en, 1'b0};
            IDX_STATUS: rd_data_c = {30'd0, done, busy};
            IDX_TRI:    rd_data_c = triangles_count;
            IDX_VTX:    rd_data_c = 32'(base_addr_vertex);
            IDX_COL:    rd_data_c = 32'(base_addr_color);
            IDX_FCNT:   rd_data_c = frame_cnt;
`ifdef GPU_REGS_ID_EN
            IDX_ID:     rd_data_c = GPU_ID;
`endif
            default:    rd_err_c  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full          <= 1'b0;
            aw_idx           <= 3'd0;
            w_full           <= 1'b0;
            w_data           <= 32'd0;
            w_strb           <= 4'd0;
            bvalid           <= 1'b0;
            bresp            <= RESP_OKAY;
            rvalid           <= 1'b0;
            rdata            <= 32'd0;
            rresp            <= RESP_OKAY;
            irq_en           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            frame_cnt        <= 32'd0;
            frame_start      <= 1'b0;
            triangles_count  <= 32'd0;
            base_addr_vertex <= '0;
            base_addr_color  <= '0;
            irq              <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_idx  <= awaddr[4:2];
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end

            if (commit_c) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
                case (aw_idx)
                    IDX_CTRL:   if (w_strb[0]) irq_en <= w_data[1];
                    IDX_STATUS: if (w_strb[0] && w_data[1]) done <= 1'b0;
                    IDX_TRI:    triangles_count <= merge_bytes(triangles_count, w_data, w_strb);
                    IDX_VTX:    base_addr_vertex <= MADDR_WIDTH'(merge_bytes(32'(base_addr_vertex), w_data, w_strb));
                    IDX_COL:    base_addr_color  <= MADDR_WIDTH'(merge_bytes(32'(base_addr_color), w_data, w_strb));
                    default: ;
                endcase
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (start_c) begin
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end

            // Placed after the DONE clear so a simultaneous set wins.
            if (frame_end && busy) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 32'd1;
            end

            irq <= done && irq_en;

            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_data_c;
                rresp  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule
